// File: rtl/id_stage_pipe.sv
// Decode stage: register file with WB write-through bypass, immediate extension,
// load-use hazard detection and a built-in ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned IMM_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [DATA_W-1:0]        if_pc,
  input  logic [31:0]              if_inst,
  input  logic                     flush,
  input  logic                     wb_we,
  input  logic [RA_W-1:0]          wb_waddr,
  input  logic [DATA_W-1:0]        wb_wdata,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [DATA_W-1:0]        ex_pc,
  output logic [DATA_W-1:0]        ex_rd1,
  output logic [DATA_W-1:0]        ex_rd2,
  output logic [DATA_W-1:0]        ex_imm,
  output logic [5:0]               ex_op,
  output logic [RA_W-1:0]          ex_rs,
  output logic [RA_W-1:0]          ex_rt,
  output logic [RA_W-1:0]          ex_rd,
  output logic [4:0]               ex_shamt,
  output logic [5:0]               ex_funct,
  input  logic                     ex_mem_read,
  output logic [(1<<RA_W)*DATA_W-1:0] dbg_regs
);

  localparam int unsigned NREG = 1 << RA_W;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [DATA_W-1:0] regs [NREG];

  logic [5:0]        op;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic              wb_hit;
  logic              bubble;

  assign op      = if_inst[31:26];
  assign rs      = if_inst[21 +: RA_W];
  assign rt      = if_inst[16 +: RA_W];
  assign rd      = if_inst[11 +: RA_W];
  assign imm_raw = if_inst[IMM_W-1:0];
  assign wb_hit  = wb_we && (wb_waddr != '0);

  // Register file storage; writes land regardless of stall or flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // Read ports with same-cycle WB write-through.
  always_comb begin
    rd1 = regs[rs];
    rd2 = regs[rt];
    if (wb_hit && (wb_waddr == rs)) rd1 = wb_wdata;
    if (wb_hit && (wb_waddr == rt)) rd2 = wb_wdata;
    if (rs == '0) rd1 = '0;
    if (rt == '0) rd2 = '0;
  end

  // Logical immediates zero-extend; everything else sign-extends.
  always_comb begin
    imm = DATA_W'($signed(imm_raw));
    if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)) imm = DATA_W'(imm_raw);
  end

  assign stall = if_valid && ex_valid && ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == rs) || (ex_rt == rt));

  assign bubble = flush || stall || !if_valid;

  always_ff @(posedge clk) begin
    if (!rst || bubble) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_op    <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_shamt <= '0;
      ex_funct <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_pc    <= if_pc;
      ex_rd1   <= rd1;
      ex_rd2   <= rd2;
      ex_imm   <= imm;
      ex_op    <= op;
      ex_rs    <= rs;
      ex_rt    <= rt;
      ex_rd    <= rd;
      ex_shamt <= if_inst[10:6];
      ex_funct <= if_inst[5:0];
    end
  end

  // Debug dump shows stored state only; slot 0 is hard zero.
  for (genvar g = 0; g < NREG; g++) begin : g_dbg
    if (g == 0) begin : g_zero
      assign dbg_regs[g*DATA_W +: DATA_W] = '0;
    end else begin : g_reg
      assign dbg_regs[g*DATA_W +: DATA_W] = regs[g];
    end
  end

endmodule
